// File: rtl/l1_packet_tx.sv
// T2-MI L1-current packet transmitter: wraps the rotating L1 store into
// header + prefix + L1 bytes + CRC-32/MPEG-2 and streams it over valid/ready.
module l1_packet_tx #(
  parameter int         L1_LEN      = 67,
  parameter logic [7:0] PACKET_TYPE = 8'h10
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  input  logic [7:0] FRAME_IDX,
  input  logic [3:0] SUPERFRAME_IDX,
  input  logic [7:0] PACKET_COUNT,
  input  logic [7:0] L1_DATA_IN,
  output logic       L1_SHIFT,
  output logic [7:0] DATA_OUT,
  output logic       DATA_VALID,
  input  logic       READY,
  output logic       SOP,
  output logic       EOP,
  output logic       BUSY
);

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_PFX, S_L1, S_CRC} state_t;

  localparam logic [15:0] PAYLOAD_LEN = 16'((L1_LEN + 2) * 8);
  localparam logic [7:0]  L1_LAST     = 8'(L1_LEN - 1);
  localparam logic [31:0] CRC_POLY    = 32'h04C11DB7;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q;
  logic [31:0] crc_q;
  logic [7:0]  frame_q, pcount_q;
  logic [3:0]  sframe_q;
  logic        last, xfer;

  function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      if (r[31] ^ d[i]) r = {r[30:0], 1'b0} ^ CRC_POLY;
      else              r = {r[30:0], 1'b0};
    end
    return r;
  endfunction

  assign DATA_VALID = (state_q != S_IDLE);
  assign BUSY       = (state_q != S_IDLE);
  assign xfer       = DATA_VALID && READY;

  always_comb begin
    state_d  = state_q;
    DATA_OUT = 8'h00;
    SOP      = 1'b0;
    EOP      = 1'b0;
    L1_SHIFT = 1'b0;
    last     = 1'b0;
    case (state_q)
      S_IDLE: if (START) state_d = S_HDR;
      S_HDR: begin
        SOP  = (cnt_q == 8'd0);
        last = (cnt_q == 8'd5);
        case (cnt_q)
          8'd0:    DATA_OUT = PACKET_TYPE;
          8'd1:    DATA_OUT = pcount_q;
          8'd2:    DATA_OUT = {sframe_q, 4'h0};
          8'd3:    DATA_OUT = 8'h00;
          8'd4:    DATA_OUT = PAYLOAD_LEN[15:8];
          default: DATA_OUT = PAYLOAD_LEN[7:0];
        endcase
        if (xfer && last) state_d = S_PFX;
      end
      S_PFX: begin
        last     = (cnt_q == 8'd1);
        DATA_OUT = (cnt_q == 8'd0) ? frame_q : 8'h00;
        if (xfer && last) state_d = S_L1;
      end
      S_L1: begin
        // store head is consumed in place; each accepted byte rotates it once
        last     = (cnt_q == L1_LAST);
        DATA_OUT = L1_DATA_IN;
        L1_SHIFT = READY;
        if (xfer && last) state_d = S_CRC;
      end
      S_CRC: begin
        last = (cnt_q == 8'd3);
        EOP  = last;
        case (cnt_q[1:0])
          2'd0:    DATA_OUT = crc_q[31:24];
          2'd1:    DATA_OUT = crc_q[23:16];
          2'd2:    DATA_OUT = crc_q[15:8];
          default: DATA_OUT = crc_q[7:0];
        endcase
        if (xfer && last) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q    <= 8'd0;
      crc_q    <= 32'hFFFFFFFF;
      frame_q  <= 8'd0;
      sframe_q <= 4'd0;
      pcount_q <= 8'd0;
    end else if (state_q == S_IDLE) begin
      if (START) begin
        cnt_q    <= 8'd0;
        crc_q    <= 32'hFFFFFFFF;
        frame_q  <= FRAME_IDX;
        sframe_q <= SUPERFRAME_IDX;
        pcount_q <= PACKET_COUNT;
      end
    end else if (xfer) begin
      // CRC stops accumulating once its own bytes are being sent
      if (state_q != S_CRC) crc_q <= crc32_byte(crc_q, DATA_OUT);
      cnt_q <= last ? 8'd0 : cnt_q + 8'd1;
    end
  end

endmodule

// File: doc/l1_packet_tx.md
Name: l1_packet_tx

Overview:
- Reads the stored L1 signalling bytes out of the parameters block's circular L1 store (its L1_DATA_OUT / L1_SHIFT side).
- Wraps them into one T2-MI L1-current packet (type 0x10): 6-byte header, 2-byte payload prefix, L1 bytes, CRC-32.
- Emits the packet as a byte stream with valid/ready handshake to the packet mux, once per START (once per T2 frame).
- After exactly L1_LEN shifts the store is back in its original order, so the same L1 data is reusable every frame.

Parameters:
- L1_LEN, 67, number of L1 signalling bytes held in the store.
- PACKET_TYPE, 8'h10, T2-MI packet_type field.

Ports:
- CLK  in  1  clock
- RST  in  1  synchronous reset, active-high
- START  in  1  one-cycle request to emit a packet; honoured only in IDLE
- FRAME_IDX  in  8  frame_idx payload byte, latched on accepted START
- SUPERFRAME_IDX  in  4  superframe_idx, latched on accepted START
- PACKET_COUNT  in  8  packet_count header byte, latched on accepted START
- L1_DATA_IN  in  8  current head byte of the L1 store (from L1_DATA_OUT)
- L1_SHIFT  out  1  rotate L1 store by one byte (to L1_SHIFT)
- DATA_OUT  out  8  packet byte
- DATA_VALID  out  1  DATA_OUT valid
- READY  in  1  downstream accepts byte when DATA_VALID && READY
- SOP  out  1  first byte of packet (qualified by DATA_VALID)
- EOP  out  1  last byte of packet (qualified by DATA_VALID)
- BUSY  out  1  high whenever state != IDLE

Behaviour:
- Reset (RST=1 at clock edge): state IDLE, byte counter 0, CRC register 32'hFFFFFFFF, latched fields 0. Outputs DATA_VALID=0, SOP=0, EOP=0, BUSY=0, L1_SHIFT=0, DATA_OUT=0.
- Transfer ("xfer") = DATA_VALID && READY. The byte counter and CRC advance only on xfer. DATA_OUT holds stable while READY=0.
- States: IDLE -> HDR (6 bytes) -> PFX (2 bytes) -> L1 (L1_LEN bytes) -> CRC (4 bytes) -> IDLE.
- IDLE:
  - START=1 latches the three input fields, moves to HDR and sets the counter to 0.
  - DATA_VALID=1 from the next cycle (1-cycle latency START -> first byte).
- HDR bytes, in order:
  - PACKET_TYPE
  - PACKET_COUNT
  - {SUPERFRAME_IDX, 4'h0}
  - 8'h00
  - payload_len[15:8]
  - payload_len[7:0]
  - payload_len = (L1_LEN+2)*8, 16-bit; 552 = 16'h0228 for the default.
- PFX bytes: FRAME_IDX, then 8'h00 (freq_source/rfu).
- L1:
  - DATA_OUT = L1_DATA_IN, combinational passthrough.
  - L1_SHIFT = (state==L1) && READY, so each consumed byte rotates the store exactly once; the next byte appears the following cycle.
  - Never more or fewer than L1_LEN shifts per completed packet.
- CRC:
  - CRC-32/MPEG-2: poly 32'h04C11DB7, init all-ones, MSB-first, no reflection, no final XOR.
  - Covers every HDR, PFX and L1 byte.
  - The value is frozen on entry to CRC and emitted MSB byte first.
  - EOP=1 on the 4th CRC byte; on its xfer, go to IDLE.
- Back-to-back packets:
  - START in the cycle of the last xfer is ignored (state not yet IDLE).
  - START in any cycle while BUSY is ignored; no queuing.
  - Minimum gap is 1 idle cycle between packets.
- CRC register reinitialises to all-ones on every accepted START.
- SOP=1 only while on HDR byte 0.
- RST mid-packet: immediate return to IDLE, no further L1_SHIFT. The store is left partially rotated; upstream must reload L1 before the next START (documented system rule).
- Counter width: 8 bits, sufficient for L1_LEN ≤ 255. L1_LEN < 1 is illegal.

Test Plan:
- Store loaded with bytes 0x00..0x42, START with FRAME_IDX=5, SUPERFRAME_IDX=3, PACKET_COUNT=0x7A, READY=1 -> 79 consecutive valid bytes:
  - header 10 7A 30 00 02 28, then 05 00 00 01 .. 42, then CRC.
  - SOP on byte 0, EOP on byte 78, exactly 67 L1_SHIFT pulses.
- Same packet fed through a golden CRC-32/MPEG-2 over all 79 bytes -> residue 32'h00000000; the 4 CRC bytes match the model.
- READY toggled pseudo-randomly (50%) -> byte sequence identical to the READY=1 case; DATA_OUT stable while READY=0; L1_SHIFT never high when READY=0.
- Two packets with a 1-cycle gap, PACKET_COUNT 0x7A then 0x7B -> L1 bytes identical in both; store order equals the original after each packet.
- START pulses at cycles 10 and 30 of an ongoing packet -> ignored; exactly one packet emitted.
- RST asserted at L1 byte 20 -> next cycle DATA_VALID=0, BUSY=0, L1_SHIFT=0. After store reload and START, a correct full packet is emitted.
